// File: rtl/spi_memory_controller.sv
// SPI mode-0 initiator: one byte read (0x03) or write (0x02) per request,
// framed as command, 24-bit address and one data byte, with a divided serial clock.
module spi_memory_controller #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ce
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] DIV_LAST     = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT     = 6'd39;
    localparam logic [5:0] FIRST_RX_BIT = 6'd32;

    logic [2:0]  r_state;
    logic [39:0] r_shift;
    logic        r_write;
    logic [5:0]  r_bitcnt;
    logic [7:0]  r_divcnt;
    logic        r_sclk;
    logic [7:0]  r_rxsr;
    logic [7:0]  r_rdata;

    logic        w_accept;
    logic        w_div_end;
    logic        w_active;
    logic [7:0]  w_cmd;

    assign req_ready = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept  = req_valid && req_ready;
    assign w_div_end = (r_divcnt == 8'd0);
    assign w_active  = (r_state == S_START) || (r_state == S_SHIFT);
    assign w_cmd     = req_write ? 8'h02 : 8'h03;

    // All outputs decode straight from reset-cleared state, so an async reset
    // drops them to idle values without waiting for a clock edge.
    assign spi_ce    = ~w_active;
    assign spi_clk   = r_sclk;
    assign spi_mosi  = w_active ? r_shift[39] : 1'b0;
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_write  <= 1'b0;
            r_bitcnt <= '0;
            r_divcnt <= '0;
            r_sclk   <= 1'b0;
            r_rxsr   <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state  <= S_START;
                        r_shift  <= {w_cmd, 8'h00, req_addr, (req_write ? req_wdata : 8'h00)};
                        r_write  <= req_write;
                        r_bitcnt <= '0;
                        r_divcnt <= DIV_LAST;
                        r_sclk   <= 1'b0;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_div_end) begin
                        r_state  <= S_SHIFT;
                        r_sclk   <= 1'b1;
                        r_divcnt <= DIV_LAST;
                    end else begin
                        r_divcnt <= r_divcnt - 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_divcnt <= r_divcnt - 8'd1;
                    end else if (r_sclk) begin
                        // Falling edge: capture miso during the data byte and
                        // advance mosi so it is stable a full half-period before the rise.
                        r_sclk   <= 1'b0;
                        r_divcnt <= DIV_LAST;
                        r_shift  <= {r_shift[38:0], 1'b0};
                        if (r_bitcnt >= FIRST_RX_BIT) begin
                            r_rxsr <= {r_rxsr[6:0], spi_miso};
                        end
                    end else if (r_bitcnt == LAST_BIT) begin
                        r_state  <= S_STOP;
                        r_divcnt <= DIV_LAST;
                    end else begin
                        r_sclk   <= 1'b1;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        r_divcnt <= DIV_LAST;
                    end
                end
                S_STOP: begin
                    if (w_div_end) begin
                        r_state <= S_DONE;
                        if (!r_write) begin
                            r_rdata <= r_rxsr;
                        end
                    end else begin
                        r_divcnt <= r_divcnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_memory_controller.sv
// Scoreboard bench: a serial SRAM responder per DUT, a reference memory
// predicting each response, and a monitor checking every rsp_valid pulse.
`timescale 1ns/1ps
module tb_spi_memory_controller;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0]       req_valid, req_ready, req_write, rsp_valid, spi_clk, spi_mosi, spi_ce;
    logic [NI-1:0][15:0] req_addr;
    logic [NI-1:0][7:0]  req_wdata, rsp_rdata;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] img(input int a);
        case (a)
            0: return 8'h3E;
            1: return 8'h03;
            2: return 8'h26;
            4: return 8'h2E;
            5: return 8'h00;
            8: return 8'hC2;
            9: return 8'h06;
            default: return 8'(a * 29 + 7);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instance 0 runs at CLK_DIV=1, instance 1 at CLK_DIV=3.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic        miso = 1'b0;
        int          cnt = 0;
        logic [39:0] rx = '0;
        logic [7:0]  cmd = '0;
        logic [15:0] addr = '0;
        logic [7:0]  b;
        logic [7:0]  cap_cmd = '0, cap_mid = '0, cap_wd = '0;
        logic [15:0] cap_addr = '0;
        logic [7:0]  mem [256];

        initial for (int i = 0; i < 256; i++) mem[i] = img(i);

        spi_memory_controller #(.CLK_DIV(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
            .spi_clk(spi_clk[g]), .spi_mosi(spi_mosi[g]), .spi_miso(miso), .spi_ce(spi_ce[g])
        );

        // Responder: samples mosi on the rise, drives the data byte after the rise.
        always @(posedge spi_clk[g] or posedge spi_ce[g]) begin
            if (spi_ce[g]) begin
                cnt = 0;
            end else begin
                rx = {rx[38:0], spi_mosi[g]};
                cnt++;
                if (cnt == 32) begin
                    cmd = rx[31:24];
                    addr = rx[15:0];
                    cap_cmd = cmd;
                    cap_mid = rx[23:16];
                    cap_addr = addr;
                end
                if (cnt >= 33 && cnt <= 40) begin
                    b = mem[addr[7:0]];
                    miso <= (cmd == 8'h03) ? b[40 - cnt] : 1'b0;
                end
                if (cnt == 40) begin
                    cap_wd = rx[7:0];
                    if (cmd == 8'h02) begin
                        mem[addr[7:0]] = rx[7:0];
                        $display("Wrote 0x%02x to 0x%06x", rx[7:0], {8'h00, addr});
                    end
                end
            end
        end
    end

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  rd;
        int          acc;
    } exp_t;
    exp_t q[$];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd = 8'h00;
    initial for (int i = 0; i < 256; i++) ref_mem[i] = img(i);

    int hi_run = 0, ce_lo = 0, last_gap = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ce_lo = 0;
            hi_run = 0;
        end else begin
            if (!spi_ce[0]) begin
                ce_lo++;
                if (hi_run > 0) last_gap = hi_run;
                hi_run = 0;
            end else begin
                hi_run++;
            end
            if (rsp_valid[0]) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_rdata", rsp_rdata[0], e.rd);
                    chk("latency", cyc, e.acc + 82);
                    chk("mosi_cmd", g_dut[0].cap_cmd, e.w ? 8'h02 : 8'h03);
                    chk("mosi_addr_hi", g_dut[0].cap_mid, 8'h00);
                    chk("mosi_addr", g_dut[0].cap_addr, e.a);
                    chk("mosi_data", g_dut[0].cap_wd, e.w ? e.d : 8'h00);
                    chk("ce_low_cycles", ce_lo, 81);
                    chk("ready_in_done", req_ready[0], 1'b1);
                end
                ce_lo = 0;
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d, output int acc);
        exp_t e;
        int n;
        acc = -1;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = w;
        req_addr[0]  = a;
        req_wdata[0] = d;
        n = 0;
        while (!req_ready[0] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[0]) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            if (w) ref_mem[a[7:0]] = d;
            else last_rd = ref_mem[a[7:0]];
            acc = cyc + 1;
            e = '{w: w, a: a, d: d, rd: last_rd, acc: acc};
            q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid[0] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, acc1_3;
        int hi, lo, bad, nhigh;
        logic got, prev;

        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_req_ready", req_ready[0], 1'b1);
        chk("rst_rsp_valid", rsp_valid[0], 1'b0);
        chk("rst_spi_ce", spi_ce[0], 1'b1);
        chk("rst_spi_clk", spi_clk[0], 1'b0);
        chk("rst_spi_mosi", spi_mosi[0], 1'b0);
        chk("rst_rsp_rdata", rsp_rdata[0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // CLK_DIV=3: read 0x0002, check half-period lengths and latency
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 16'h0002; req_wdata[1] = 8'hFF;
        acc1_3 = cyc + 1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        hi = 0; lo = 0; bad = 0; nhigh = 0; got = 1'b0; prev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid[1]) begin
                got = 1'b1;
                break;
            end
            if (!spi_ce[1]) begin
                if (spi_clk[1]) begin
                    if (!prev) begin
                        if (lo != 3) bad++;
                        lo = 0;
                        nhigh++;
                    end
                    hi++;
                end else begin
                    if (prev) begin
                        if (hi != 3) bad++;
                        hi = 0;
                    end
                    lo++;
                end
                prev = spi_clk[1];
            end
            @(negedge clk);
        end
        chk("cd3_rsp_seen", got, 1'b1);
        chk("cd3_latency", cyc, acc1_3 + 246);
        chk("cd3_rdata", rsp_rdata[1], 8'h26);
        chk("cd3_bad_halfperiods", bad, 0);
        chk("cd3_sclk_pulses", nhigh, 40);

        // CLK_DIV=1 directed traffic
        issue(1'b0, 16'h0000, 8'hA5, acc1); idle(); drain();
        issue(1'b0, 16'h0008, 8'h00, acc1); idle(); drain();
        issue(1'b0, 16'h0009, 8'h00, acc1); idle(); drain();
        issue(1'b1, 16'h0003, 8'h5A, acc1); idle(); drain();
        issue(1'b0, 16'h0003, 8'h00, acc1); idle(); drain();

        // back-to-back with req_valid held; second accepted in DONE
        issue(1'b0, 16'h0004, 8'h00, acc1);
        issue(1'b0, 16'h0005, 8'h00, acc2);
        idle(); drain();
        chk("b2b_accept_gap", acc2 - acc1, 83);
        chk("b2b_ce_high_gap", (last_gap >= 1 && last_gap <= 2) ? 1 : 0, 1);

        for (int i = 0; i < 10; i++) begin
            issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), acc1);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle(); drain();

        // async reset during bit 20 of the shift phase
        issue(1'b0, 16'h0007, 8'h00, acc1);
        idle();
        while (cyc < acc1 + 41) @(negedge clk);
        chk("pre_rst_ce_low", spi_ce[0], 1'b0);
        chk("pre_rst_sclk_high", spi_clk[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_spi_ce", spi_ce[0], 1'b1);
        chk("arst_spi_clk", spi_clk[0], 1'b0);
        chk("arst_req_ready", req_ready[0], 1'b1);
        chk("arst_rsp_valid", rsp_valid[0], 1'b0);
        chk("arst_spi_mosi", spi_mosi[0], 1'b0);
        chk("arst_rsp_rdata", rsp_rdata[0], 8'h00);
        q.delete();
        last_rd = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 16'h0001, 8'h00, acc1); idle(); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
